// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and region encoding for the CPU data path.
// ROM, MMR and stack blocks import this so all of them agree on the map.
package mem_map_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam logic [ADDR_W-1:0] INSTR_END = 12'h400;
   localparam logic [ADDR_W-1:0] MMR_END   = 12'h44B;

   typedef enum logic [1:0] {
      REG_INSTR = 2'd0,
      REG_MMR   = 2'd1,
      REG_STACK = 2'd2
   } region_e;

   // Default-map decode, for blocks that only need the standard layout
   function automatic region_e addr_to_region(input logic [ADDR_W-1:0] addr);
      if (addr <= INSTR_END)    return REG_INSTR;
      else if (addr <= MMR_END) return REG_MMR;
      else                      return REG_STACK;
   endfunction

endpackage

// File: rtl/mem_addr_region_decoder.sv
// Classifies CPU addresses into ROM / MMR / stack, gates the store strobe to
// the writable target, and keeps a registered select for synchronous read data.
module mem_addr_region_decoder
   import mem_map_pkg::*;
#(
   parameter int unsigned        P_ADDR_W    = ADDR_W,
   parameter logic [P_ADDR_W-1:0] P_INSTR_END = INSTR_END,
   parameter logic [P_ADDR_W-1:0] P_MMR_END   = MMR_END
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [P_ADDR_W-1:0] addr,
   input  logic                MEMLOAD,
   output logic [1:0]          sel,
   output logic                load_mmr,
   output logic                load_stack,
   output logic [1:0]          sel_q,
   output logic                rom_wr_err
);

   // Stack must hold at least one address above the MMR block
   if (!((P_INSTR_END < P_MMR_END) && (P_MMR_END < {P_ADDR_W{1'b1}}))) begin : g_bad_map
      $fatal(1, "mem_addr_region_decoder: illegal INSTR_END/MMR_END");
   end

   region_e     region;
   logic [1:0]  sel_d;
   logic        rom_wr_err_d;

   always_comb begin
      region = REG_STACK;
      if (addr <= P_INSTR_END)    region = REG_INSTR;
      else if (addr <= P_MMR_END) region = REG_MMR;
   end

   assign sel        = region;
   assign load_mmr   = MEMLOAD && (region == REG_MMR);
   assign load_stack = MEMLOAD && (region == REG_STACK);

   assign sel_d        = sel;
   assign rom_wr_err_d = rom_wr_err | (MEMLOAD && (region == REG_INSTR));

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q      <= REG_INSTR;
         rom_wr_err <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         rom_wr_err <= rom_wr_err_d;
      end
   end

endmodule

// File: tb/tb_mem_addr_region_decoder.sv
// Directed bench for mem_addr_region_decoder: full decode sweeps, boundaries,
// registered select timing, sticky ROM-write error and reset independence.
module tb_mem_addr_region_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr;
   logic        MEMLOAD;
   logic [1:0]  sel;
   logic        load_mmr;
   logic        load_stack;
   logic [1:0]  sel_q;
   logic        rom_wr_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_addr_region_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .MEMLOAD    (MEMLOAD),
      .sel        (sel),
      .load_mmr   (load_mmr),
      .load_stack (load_stack),
      .sel_q      (sel_q),
      .rom_wr_err (rom_wr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge
   task automatic drive(input logic r, input logic [11:0] a, input logic m);
      @(negedge clk);
      rst = r; addr = a; MEMLOAD = m;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_sel;
      rst = 1'b1; addr = '0; MEMLOAD = 1'b0;

      for (int m = 1; m >= 0; m--) begin
         MEMLOAD = m[0];
         for (int a = 0; a < 4096; a++) begin
            addr = a[11:0];
            #1;
            exp_sel = (a <= 'h400) ? 2'd0 : (a <= 'h44B) ? 2'd1 : 2'd2;
            chk("sweep_sel",        sel,        exp_sel);
            chk("sweep_load_mmr",   load_mmr,   m[0] && exp_sel == 2'd1);
            chk("sweep_load_stack", load_stack, m[0] && exp_sel == 2'd2);
         end
      end

      addr = 12'h400; #1; chk("bnd_400", sel, 2'd0);
      addr = 12'h401; #1; chk("bnd_401", sel, 2'd1);
      addr = 12'h44B; #1; chk("bnd_44b", sel, 2'd1);
      addr = 12'h44C; #1; chk("bnd_44c", sel, 2'd2);
      addr = 12'hFFF; #1; chk("bnd_fff", sel, 2'd2);

      drive(1'b1, 12'h000, 1'b0); tick;
      drive(1'b1, 12'h000, 1'b0); tick;
      chk("rst_sel_q",   sel_q,      2'd0);
      chk("rst_rom_err", rom_wr_err, 1'b0);

      drive(1'b0, 12'h450, 1'b0);
      #1 chk("selq_pre_450", sel_q, 2'd0);
      chk("sel_450", sel, 2'd2);
      tick;
      chk("selq_450", sel_q, 2'd2);
      drive(1'b0, 12'h410, 1'b0);
      #1 chk("sel_410", sel, 2'd1);
      chk("selq_hold_450", sel_q, 2'd2);
      tick;
      chk("selq_410", sel_q, 2'd1);

      drive(1'b0, 12'h100, 1'b1);
      #1 chk("romerr_pre", rom_wr_err, 1'b0);
      chk("rom_no_loads", {load_mmr, load_stack}, 2'b00);
      tick;
      chk("romerr_set", rom_wr_err, 1'b1);
      drive(1'b0, 12'h500, 1'b0); tick;
      chk("romerr_sticky", rom_wr_err, 1'b1);
      chk("selq_500", sel_q, 2'd2);
      drive(1'b1, 12'h500, 1'b0); tick;
      chk("romerr_clr", rom_wr_err, 1'b0);
      chk("selq_rst", sel_q, 2'd0);

      drive(1'b1, 12'h100, 1'b1); tick;
      chk("romerr_rst_prio", rom_wr_err, 1'b0);

      drive(1'b1, 12'h420, 1'b1);
      #1 chk("rstind_sel", sel, 2'd1);
      chk("rstind_load_mmr",   load_mmr,   1'b1);
      chk("rstind_load_stack", load_stack, 1'b0);
      tick;
      chk("rstind_sel_q", sel_q, 2'd0);

      drive(1'b0, 12'hFFF, 1'b1); tick;
      chk("stack_load", load_stack, 1'b1);
      chk("selq_fff", sel_q, 2'd2);
      chk("romerr_stack", rom_wr_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_addr_region_decoder.md
Name: mem_addr_region_decoder

Overview:
Address-region decoder for the CPU data-memory path. It classifies each 12-bit memory address into one of three regions: instruction ROM, memory-mapped registers (MMR) or stack RAM. It drives the read-data mux select and gates the CPU store strobe (MEMLOAD) to the correct writable target. It sits between the CPU address/control outputs and the ROM/MMR/stack blocks. A registered copy of the select aligns with synchronous memory read data.

Parameters:
ADDR_W, 12, address width in bits
INSTR_END, 12'h400, last address of the instruction region (inclusive)
MMR_END, 12'h44B, last address of the MMR region (inclusive); stack runs from MMR_END+1 to 2^ADDR_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
addr  in  ADDR_W  memory address from the CPU
MEMLOAD  in  1  CPU store strobe (write request)
sel  out  2  combinational region select: 0 = instructions, 1 = MMR, 2 = stack
load_mmr  out  1  write enable to the MMR bank
load_stack  out  1  write enable to the stack RAM
sel_q  out  2  sel registered one clock later, for the read-data mux
rom_wr_err  out  1  sticky flag: a store was attempted into the instruction region

Behaviour:
- Region decode, purely combinational, zero latency, unsigned compares:
  - instructions: 0 <= addr <= INSTR_END → sel=0
  - MMR: INSTR_END+1 <= addr <= MMR_END → sel=1
  - stack: MMR_END+1 <= addr <= 2^ADDR_W-1 → sel=2
- sel=3 is never driven.
- Boundary values with default parameters: 0x400 → 0; 0x401 → 1; 0x44B → 1; 0x44C → 2; 0xFFF → 2.
- load_mmr = MEMLOAD AND (sel==1).
- load_stack = MEMLOAD AND (sel==2).
- In the instruction region both load_mmr and load_stack are 0, regardless of MEMLOAD (ROM is read-only).
- load_mmr and load_stack are never both 1.
- The combinational outputs do not depend on clk or rst. They are valid during reset.
- sel_q:
  - On each rising clk edge, sel_q <= sel.
  - When rst=1 at a clock edge, sel_q <= 0.
  - Latency is exactly 1 cycle.
- rom_wr_err:
  - Set at a rising edge when MEMLOAD=1 and sel=0.
  - Stays 1 until rst.
  - rst has priority over a simultaneous set: reset value 0.
- Reset mid-operation: only sel_q and rom_wr_err are affected. Decode continues combinationally.
- Parameter legality: 0 <= INSTR_END < MMR_END < 2^ADDR_W-1. Check this with an elaboration-time assertion.

Decomposition:
- Shared package mem_map_pkg holds:
  - region enum (REG_INSTR=2'd0, REG_MMR=2'd1, REG_STACK=2'd2)
  - ADDR_W
  - INSTR_END and MMR_END default constants
  - the same constants also serve the MMR and stack blocks for local offsets
- No sub-module is needed. The combinational decode can optionally be a function in mem_map_pkg (addr_to_region) so other blocks decode identically.

Test Plan:
- Exhaustive sweep with MEMLOAD=1, addr 0x000..0xFFF:
  - 0x000–0x400 → sel=0, load_mmr=0, load_stack=0
  - 0x401–0x44B → sel=1, load_mmr=1, load_stack=0
  - 0x44C–0xFFF → sel=2, load_mmr=0, load_stack=1
- Same sweep with MEMLOAD=0 → sel unchanged from the MEMLOAD=1 sweep; load_mmr=load_stack=0 everywhere.
- Boundary pairs 0x400/0x401, 0x44B/0x44C, 0xFFF → sel 0/1, 1/2, 2. Verify no X and sel never 3.
- sel_q timing:
  - rst=1 for 2 cycles → sel_q=0.
  - Release rst, drive addr 0x450, then 0x410 on consecutive cycles → sel_q = 2 then 1, each one cycle after sel.
- rom_wr_err:
  - addr=0x100, MEMLOAD=1 for one cycle → rom_wr_err=1 next edge and remains 1 after MEMLOAD drops and addr moves to 0x500.
  - Assert rst → 0.
  - rst and a ROM store in the same cycle → rom_wr_err stays 0.
- Reset independence: hold rst=1 and drive addr=0x420, MEMLOAD=1 → load_mmr=1 and sel=1 immediately, while sel_q stays 0.
